// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access encodings,
// FSM state type and small decode helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_WR0,
      ST_WR1,
      ST_DONE
   } lsu_state_e;

   // Encodings 3, 6 and 7 are not memory access types.
   function automatic logic is_illegal(input logic [2:0] f3);
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

   // True when the access spills into the next aligned word.
   function automatic logic is_cross(input logic [2:0] f3, input logic [1:0] off);
      if (f3 == F3_H || f3 == F3_HU) return (off == 2'd3);
      if (f3 == F3_W)                return (off != 2'd0);
      return 1'b0;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and data-memory port bundle of the LSU.
interface load_store_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_req;
   logic                  mem_write;
   logic [2:0]            funct3;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  stall;
   logic                  done;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  err;
   logic [ADDR_WIDTH-1:0] dm_a;
   logic [DATA_WIDTH-1:0] dm_wd;
   logic                  dm_we;
   logic [DATA_WIDTH-1:0] dm_rd;

   // LSU side
   modport slave (
      input  mem_req, mem_write, funct3, addr, wdata, dm_rd,
      output stall, done, rdata, err, dm_a, dm_wd, dm_we
   );

   // Pipeline plus data memory side
   modport master (
      output mem_req, mem_write, funct3, addr, wdata, dm_rd,
      input  stall, done, rdata, err, dm_a, dm_wd, dm_we
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane extraction for loads and byte-lane merge for stores over the
// two buffered memory words {buf1, buf0}.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_buf0,
   input  logic [31:0] i_buf1,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_load,
   output logic [31:0] o_wd0,
   output logic [31:0] o_wd1
);

   logic [63:0] w_pair;
   logic [31:0] w_shifted;
   logic [3:0]  w_size_lanes;
   logic [7:0]  w_lanes;
   logic [63:0] w_mask;
   logic [63:0] w_data_sh;
   logic [63:0] w_merged;

   assign w_pair    = {i_buf1, i_buf0};
   assign w_shifted = 32'(w_pair >> {i_off, 3'b000});

   // Load result: pick the addressed lanes and extend them.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      o_load = '0;
      case (i_funct3)
         F3_B:    o_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_H:    o_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_W:    o_load = w_shifted;
         F3_BU:   o_load = {24'd0, w_shifted[7:0]};
         F3_HU:   o_load = {16'd0, w_shifted[15:0]};
         default: o_load = '0;
      endcase
   end

   // Byte enables of the store across both words.
   always_comb begin
      w_size_lanes = 4'b0001;
      case (i_funct3[1:0])
         2'd1:    w_size_lanes = 4'b0011;
         2'd2:    w_size_lanes = 4'b1111;
         default: w_size_lanes = 4'b0001;
      endcase
      w_lanes = {4'b0000, w_size_lanes} << i_off;
      for (int i = 0; i < 8; i++) begin
         w_mask[8*i +: 8] = {8{w_lanes[i]}};
      end
   end

   assign w_data_sh = {32'd0, i_wdata} << {i_off, 3'b000};
   assign w_merged  = (w_pair & ~w_mask) | (w_data_sh & w_mask);
   assign o_wd0     = w_merged[31:0];
   assign o_wd1     = w_merged[63:32];

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: handles misaligned and sub-word accesses
// against a word-wide data memory using read-modify-write sequences.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   load_store_unit_if.slave  bus
);

   lsu_state_e            r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_buf0;
   logic [DATA_WIDTH-1:0] r_buf1;
   logic [2:0]            r_funct3;
   logic                  r_write;

   logic [ADDR_WIDTH-1:0] w_base;
   logic [ADDR_WIDTH-1:0] w_base_next;
   logic [1:0]            w_off;
   logic                  w_cross;
   logic                  w_illegal;
   logic                  w_in_illegal;
   logic                  w_in_aligned_sw;
   logic [DATA_WIDTH-1:0] w_load;
   logic [DATA_WIDTH-1:0] w_wd0;
   logic [DATA_WIDTH-1:0] w_wd1;

   assign w_base          = {r_addr[ADDR_WIDTH-1:2], 2'b00};
   assign w_base_next     = w_base + ADDR_WIDTH'(4);
   assign w_off           = r_addr[1:0];
   assign w_cross         = is_cross(r_funct3, w_off);
   assign w_illegal       = is_illegal(r_funct3);
   assign w_in_illegal    = is_illegal(bus.funct3);
   assign w_in_aligned_sw = bus.mem_write && (bus.funct3 == F3_W) && (bus.addr[1:0] == 2'b00);

   lsu_lane_align u_lane_align (
      .i_buf0   (r_buf0),
      .i_buf1   (r_buf1),
      .i_wdata  (r_wdata),
      .i_off    (w_off),
      .i_funct3 (r_funct3),
      .o_load   (w_load),
      .o_wd0    (w_wd0),
      .o_wd1    (w_wd1)
   );

   // Access sequencer: captures the request and walks the read/write phases.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the word buffers are plain registers, so they are cleared with the rest of the state.
         r_state  <= ST_IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_buf0   <= '0;
         r_buf1   <= '0;
         r_funct3 <= '0;
         r_write  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         case (r_state)
            ST_IDLE: begin
               if (bus.mem_req) begin
                  r_addr   <= bus.addr;
                  r_wdata  <= bus.wdata;
                  r_funct3 <= bus.funct3;
                  r_write  <= bus.mem_write;
                  if (w_in_illegal)         r_state <= ST_DONE;
                  else if (w_in_aligned_sw) r_state <= ST_WR0;
                  else                      r_state <= ST_RD0;
               end
            end
            ST_RD0: begin
               r_buf0 <= bus.dm_rd;
               if (w_cross)      r_state <= ST_RD1;
               else if (r_write) r_state <= ST_WR0;
               else              r_state <= ST_DONE;
            end
            ST_RD1: begin
               r_buf1  <= bus.dm_rd;
               r_state <= r_write ? ST_WR0 : ST_DONE;
            end
            ST_WR0:  r_state <= w_cross ? ST_WR1 : ST_DONE;
            ST_WR1:  r_state <= ST_DONE;
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Output decode from the current state.
   always_comb begin
      bus.stall = 1'b0;
      bus.done  = 1'b0;
      bus.err   = 1'b0;
      bus.rdata = '0;
      bus.dm_a  = '0;
      bus.dm_wd = '0;
      bus.dm_we = 1'b0;
      case (r_state)
         ST_IDLE: bus.stall = bus.mem_req;
         ST_RD0: begin
            bus.stall = 1'b1;
            bus.dm_a  = w_base;
         end
         ST_RD1: begin
            bus.stall = 1'b1;
            bus.dm_a  = w_base_next;
         end
         ST_WR0: begin
            bus.stall = 1'b1;
            bus.dm_a  = w_base;
            bus.dm_wd = w_wd0;
            bus.dm_we = 1'b1;
         end
         ST_WR1: begin
            bus.stall = 1'b1;
            bus.dm_a  = w_base_next;
            bus.dm_wd = w_wd1;
            bus.dm_we = 1'b1;
         end
         ST_DONE: begin
            bus.done  = 1'b1;
            bus.err   = w_illegal;
            bus.rdata = (w_illegal || r_write) ? '0 : w_load;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-addressed memory model.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic [31:0] mem [0:1023];
   int          we_count = 0;
   logic [31:0] a_hist [0:15];
   int          lat;
   logic [31:0] res_rdata;
   logic        res_err;
   int          we_delta;

   load_store_unit_if bus_if ();

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   assign bus_if.dm_rd = mem[bus_if.dm_a[11:2]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic mem_set(input logic [31:0] a, input logic [31:0] v);
      mem[a[11:2]] = v;
   endtask

   function automatic logic [31:0] mem_get(input logic [31:0] a);
      return mem[a[11:2]];
   endfunction

   // One clock: memory write sampled at the negative edge, applied at the edge.
   task automatic step();
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      @(negedge clk);
      we = bus_if.dm_we;
      a  = bus_if.dm_a;
      wd = bus_if.dm_wd;
      @(posedge clk);
      if (we) begin
         mem[a[11:2]] = wd;
         we_count++;
      end
      #1;
   endtask

   task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input string tag);
      int   start_we;
      logic got_done;
      step();
      bus_if.mem_req   = 1'b1;
      bus_if.mem_write = wr;
      bus_if.funct3    = f3;
      bus_if.addr      = a;
      bus_if.wdata     = wd;
      #1;
      check({tag, ":req_stall"}, 32'(bus_if.stall), 32'd1);
      check({tag, ":req_notdone"}, 32'(bus_if.done), 32'd0);
      start_we  = we_count;
      got_done  = 1'b0;
      lat       = 0;
      res_rdata = 'x;
      res_err   = 1'bx;
      for (int k = 1; k <= 12 && !got_done; k++) begin
         step();
         lat       = k;
         a_hist[k] = bus_if.dm_a;
         if (bus_if.done) begin
            got_done  = 1'b1;
            res_rdata = bus_if.rdata;
            res_err   = bus_if.err;
            check({tag, ":done_stall"}, 32'(bus_if.stall), 32'd0);
            bus_if.mem_req = 1'b0;
         end
      end
      check({tag, ":timeout"}, 32'(got_done), 32'd1);
      we_delta = we_count - start_we;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      rst              = 1'b1;
      bus_if.mem_req   = 1'b0;
      bus_if.mem_write = 1'b0;
      bus_if.funct3    = 3'd0;
      bus_if.addr      = 32'd0;
      bus_if.wdata     = 32'd0;
      step();
      step();
      check("rst:stall", 32'(bus_if.stall), 32'd0);
      check("rst:done",  32'(bus_if.done),  32'd0);
      check("rst:err",   32'(bus_if.err),   32'd0);
      check("rst:dm_we", 32'(bus_if.dm_we), 32'd0);
      check("rst:dm_a",  bus_if.dm_a,       32'd0);
      check("rst:dm_wd", bus_if.dm_wd,      32'd0);
      check("rst:rdata", bus_if.rdata,      32'd0);
      rst = 1'b0;

      // LB at offset 1, aligned
      mem_set(32'h100, 32'h8899AABB);
      do_req(1'b0, 3'd0, 32'h101, 32'h0, "lb");
      check("lb:lat",   32'(lat),      32'd2);
      check("lb:rdata", res_rdata,     32'hFFFFFFAA);
      check("lb:err",   32'(res_err),  32'd0);
      check("lb:we",    32'(we_delta), 32'd0);

      // LW crossing words
      mem_set(32'h100, 32'h44332211);
      mem_set(32'h104, 32'h88776655);
      do_req(1'b0, 3'd2, 32'h102, 32'h0, "lw_x");
      check("lw_x:a1",    a_hist[1], 32'h100);
      check("lw_x:a2",    a_hist[2], 32'h104);
      check("lw_x:lat",   32'(lat),  32'd3);
      check("lw_x:rdata", res_rdata, 32'h66554433);
      check("lw_x:we",    32'(we_delta), 32'd0);

      // SB at offset 3; upper wdata bytes must be ignored
      mem_set(32'h200, 32'h11223344);
      do_req(1'b1, 3'd0, 32'h203, 32'h123456EF, "sb");
      check("sb:lat", 32'(lat),           32'd3);
      check("sb:we",  32'(we_delta),      32'd1);
      check("sb:mem", mem_get(32'h200),   32'hEF223344);

      // SW crossing words
      mem_set(32'h0FC, 32'h00000000);
      mem_set(32'h100, 32'hFFFFFFFF);
      do_req(1'b1, 3'd2, 32'h0FE, 32'hDEADBEEF, "sw_x");
      check("sw_x:lat",  32'(lat),         32'd5);
      check("sw_x:we",   32'(we_delta),    32'd2);
      check("sw_x:mem0", mem_get(32'h0FC), 32'hBEEF0000);
      check("sw_x:mem1", mem_get(32'h100), 32'hFFFFDEAD);

      // Aligned SW goes straight to the write
      do_req(1'b1, 3'd2, 32'h200, 32'hCAFEF00D, "sw_a");
      check("sw_a:lat", 32'(lat),         32'd2);
      check("sw_a:we",  32'(we_delta),    32'd1);
      check("sw_a:mem", mem_get(32'h200), 32'hCAFEF00D);

      // LHU / LBU zero extension
      do_req(1'b0, 3'd5, 32'h202, 32'h0, "lhu");
      check("lhu:lat",   32'(lat),  32'd2);
      check("lhu:rdata", res_rdata, 32'h0000CAFE);
      do_req(1'b0, 3'd4, 32'h201, 32'h0, "lbu");
      check("lbu:rdata", res_rdata, 32'h000000F0);

      // LH wrapping past the top of the address space
      mem_set(32'hFFFFFFFC, 32'h9A000000);
      mem_set(32'h00000000, 32'h000000BC);
      do_req(1'b0, 3'd1, 32'hFFFFFFFF, 32'h0, "lh_wrap");
      check("lh_wrap:a1",    a_hist[1], 32'hFFFFFFFC);
      check("lh_wrap:a2",    a_hist[2], 32'h00000000);
      check("lh_wrap:lat",   32'(lat),  32'd3);
      check("lh_wrap:rdata", res_rdata, 32'hFFFFBC9A);

      // Illegal funct3 values, including as a store
      do_req(1'b0, 3'd3, 32'h100, 32'h0, "ill3");
      check("ill3:lat",   32'(lat),      32'd1);
      check("ill3:err",   32'(res_err),  32'd1);
      check("ill3:rdata", res_rdata,     32'd0);
      check("ill3:we",    32'(we_delta), 32'd0);
      mem_set(32'h100, 32'h55555555);
      do_req(1'b1, 3'd7, 32'h100, 32'hFFFFFFFF, "ill7");
      check("ill7:err", 32'(res_err),      32'd1);
      check("ill7:we",  32'(we_delta),     32'd0);
      check("ill7:mem", mem_get(32'h100),  32'h55555555);

      // SH crossing at offset 3
      mem_set(32'h100, 32'h44332211);
      mem_set(32'h104, 32'h88776655);
      do_req(1'b1, 3'd1, 32'h103, 32'h0000A577, "sh_x");
      check("sh_x:lat",  32'(lat),         32'd5);
      check("sh_x:mem0", mem_get(32'h100), 32'h77332211);
      check("sh_x:mem1", mem_get(32'h104), 32'h887766A5);

      // Back-to-back aligned LW right after the previous DONE
      do_req(1'b0, 3'd2, 32'h104, 32'h0, "lw_a");
      check("lw_a:lat",   32'(lat),  32'd2);
      check("lw_a:rdata", res_rdata, 32'h887766A5);

      // Reset while in RD1 of a crossing SW
      mem_set(32'h0FC, 32'h11111111);
      mem_set(32'h100, 32'h22222222);
      step();
      bus_if.mem_req   = 1'b1;
      bus_if.mem_write = 1'b1;
      bus_if.funct3    = 3'd2;
      bus_if.addr      = 32'h0FE;
      bus_if.wdata     = 32'hDEADBEEF;
      lat = we_count;
      step();
      step();
      check("rst_mid:rd1_addr", bus_if.dm_a, 32'h100);
      rst            = 1'b1;
      bus_if.mem_req = 1'b0;
      step();
      check("rst_mid:stall", 32'(bus_if.stall), 32'd0);
      check("rst_mid:dm_we", 32'(bus_if.dm_we), 32'd0);
      check("rst_mid:dm_a",  bus_if.dm_a,       32'd0);
      rst = 1'b0;
      step();
      step();
      check("rst_mid:we",   32'(we_count - lat), 32'd0);
      check("rst_mid:mem0", mem_get(32'h0FC),    32'h11111111);
      check("rst_mid:mem1", mem_get(32'h100),    32'h22222222);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data word width; only 32 is supported.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 The block SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 mem_req  input  1  pipeline memory-stage access request; held stable while stall is high.
REQ-007 mem_write  input  1  1 = store, 0 = load.
REQ-008 funct3  input  3  access type: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
REQ-009 addr  input  ADDR_WIDTH  byte address; any alignment permitted.
REQ-010 wdata  input  DATA_WIDTH  store data; the low byte, half or word is used.
REQ-011 stall  output  1  freezes the pipeline while the access is incomplete.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 rdata  output  DATA_WIDTH  extended load result; valid only while done is high.
REQ-014 err  output  1  illegal funct3, qualified by done.
REQ-015 dm_a  output  ADDR_WIDTH  word-aligned address to data memory.
REQ-016 dm_wd  output  DATA_WIDTH  full-word write data to data memory.
REQ-017 dm_we  output  1  data memory write enable (whole-word write).
REQ-018 dm_rd  input  DATA_WIDTH  data memory combinational read data for dm_a.

Function
REQ-019 The FSM states SHALL be IDLE, RD0, RD1, WR0, WR1 and DONE.
REQ-020 Term definitions:
- base = addr with bits [1:0] cleared.
- off = addr[1:0].
- cross = (half and off=3) or (word and off!=0).
REQ-021 IDLE with mem_req=1 SHALL capture addr, wdata, funct3 and mem_write, and SHALL assert stall combinationally.
- Next state is WR0 for an aligned SW.
- Next state is DONE for an illegal funct3.
- Next state is RD0 otherwise.
REQ-022 RD0 SHALL drive dm_a=base and register dm_rd into buf0.
- Next state is RD1 if cross.
- Otherwise next is WR0 for a store and DONE for a load.
REQ-023 RD1 SHALL drive dm_a=base+4 (modulo 2^ADDR_WIDTH) and register dm_rd into buf1.
- Next state is WR0 for a store and DONE for a load.
REQ-024 WR0 SHALL drive dm_a=base, dm_wd=buf0 with the low store lanes merged, and dm_we=1.
- Next state is WR1 if cross, DONE otherwise.
REQ-025 WR1 SHALL drive dm_a=base+4, dm_wd=buf1 with the spilled store lanes merged, and dm_we=1.
- Next state is DONE.
REQ-026 DONE SHALL drive done=1 and stall=0, and SHALL always go to IDLE.
REQ-027 stall SHALL equal (state!=IDLE and state!=DONE) or (state==IDLE and mem_req).
REQ-028 Load result selection SHALL be {buf1,buf0} shifted right by 8*off.
- LB and LH sign-extend.
- LBU and LHU zero-extend.
- LW passes the word through.
REQ-029 Store merge SHALL replace only the addressed bytes; all other bytes are rewritten with their read values.
REQ-030 In IDLE and DONE, dm_we SHALL be 0 and dm_a SHALL be 0.
REQ-031 dm_we SHALL never be asserted for loads or illegal accesses.
REQ-032 An illegal funct3 (3, 6 or 7) SHALL complete with err=1, rdata=0 and no memory write.
REQ-033 Latencies from the request cycle to the done cycle:
- aligned load: 2 cycles.
- crossing load: 3 cycles.
- aligned SW: 2 cycles.
- aligned SB/SH: 3 cycles.
- crossing store: 5 cycles.
REQ-034 Back-to-back requests SHALL each begin in the IDLE cycle after DONE.

Reset
REQ-035 When rst=1 at a clock edge, the state SHALL become IDLE and buf0, buf1 and all captured request registers SHALL clear to 0.
REQ-036 Out of reset, stall, done, err, dm_we, dm_a, dm_wd and rdata SHALL be 0.
REQ-037 A reset mid-operation SHALL abandon the access with no further dm_we.
- A WR0 write already committed before the reset edge is not undone.

Structure
REQ-038 Package lsu_pkg SHALL hold the funct3 encoding constants and the state enum typedef.
REQ-039 The lane extract and merge logic SHALL be a combinational sub-module, lsu_lane_align, instantiated once.

Verification
REQ-040 Memory word 0x100=0x8899AABB; LB 0x101 -> done at +2 cycles, rdata=0xFFFFFFAA, no dm_we.
REQ-041 0x100=0x44332211, 0x104=0x88776655; LW 0x102 -> RD0, RD1 sequence, rdata=0x66554433, done at +3.
REQ-042 0x200=0x11223344; SB 0x203, wdata=0xEF -> 0x200=0xEF223344, single dm_we cycle, done at +3.
REQ-043 SW 0x0FE, wdata=0xDEADBEEF, old 0x0FC=0x00000000 and 0x100=0xFFFFFFFF -> 0x0FC=0xBEEF0000, 0x100=0xFFFFDEAD, done at +5.
REQ-044 LH 0xFFFFFFFF -> second read dm_a=0x00000000; funct3=3 -> err=1, no dm_we.
REQ-045 rst asserted in RD1 of a crossing SW -> next cycle IDLE, zero dm_we, memory unchanged.
